// File: rtl/mips_cpu_mem_master.sv
// mips_cpu_mem_master: CPU load/store bus initiator with byte lanes, load extension and waitrequest timeout.
// Define MIPS_MEM_LWLR_EN to make LWL/LWR (op 8/9) legal with their merge logic.
module mips_cpu_mem_master #(
   parameter int WAIT_LIMIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [3:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);
   typedef enum logic [1:0] {IDLE, ISSUE_RD, ISSUE_WR, CAPTURE} state_t;
   state_t state_q, state_d;
   logic [3:0] op_q, op_d, be_q, be_d, be_sel;
   logic [1:0] k, k_q, k_d;
   logic [31:0] cnt_q, cnt_d, rdata_q, rdata_d, address_q, address_d, writedata_q, writedata_d;
   logic [31:0] wd_sel, ld_val, sh;
   logic read_q, read_d, write_q, write_d, done_q, done_d, err_q, err_d;
   logic is_store, lwlr, bad, start, issuing, timeout;
   assign k = addr[1:0];
   assign is_store = op == 4'd5 || op == 4'd6 || op == 4'd7;
`ifdef MIPS_MEM_LWLR_EN
   assign lwlr = op == 4'd8 || op == 4'd9;
`else
   assign lwlr = 1'b0;
`endif
   assign bad = (op > 4'd7 && !lwlr) || ((op == 4'd2 || op == 4'd3 || op == 4'd6) && k[0])
              || ((op == 4'd4 || op == 4'd7) && k != 2'd0);
   assign start = state_q == IDLE && req && !bad;
   assign issuing = state_q == ISSUE_RD || state_q == ISSUE_WR;
   assign timeout = WAIT_LIMIT != 0 && waitrequest && cnt_q == 32'(WAIT_LIMIT - 1);
   always_comb begin
      be_sel = (op == 4'd0 || op == 4'd1 || op == 4'd5) ? 4'b0001 << k :
               (op == 4'd2 || op == 4'd3 || op == 4'd6) ? (k[1] ? 4'b1100 : 4'b0011) :
               op == 4'd8 ? 4'b1111 >> (2'd3 - k) :
               op == 4'd9 ? 4'b1111 << k : 4'b1111;
      wd_sel = op == 4'd5 ? {4{wdata[7:0]}} : op == 4'd6 ? {2{wdata[15:0]}} : wdata;
   end
   // Lane-aligned view of the returned word; halves only ever sit at offset 0 or 2.
   assign sh = readdata >> {k_q, 3'b000};
`ifdef MIPS_MEM_LWLR_EN
   logic [31:0] wdata_q;
   always_ff @(posedge clk) begin
      if (reset) wdata_q <= '0;
      else if (start) wdata_q <= wdata;
   end
   always_comb
      ld_val = op_q == 4'd0 ? {{24{sh[7]}}, sh[7:0]} :
               op_q == 4'd1 ? {24'd0, sh[7:0]} :
               op_q == 4'd2 ? {{16{sh[15]}}, sh[15:0]} :
               op_q == 4'd3 ? {16'd0, sh[15:0]} :
               op_q == 4'd8 ? (readdata << {2'd3 - k_q, 3'b000}) | (wdata_q & ~(32'hFFFF_FFFF << {2'd3 - k_q, 3'b000})) :
               op_q == 4'd9 ? sh | (wdata_q & ~(32'hFFFF_FFFF >> {k_q, 3'b000})) : readdata;
`else
   always_comb
      ld_val = op_q == 4'd0 ? {{24{sh[7]}}, sh[7:0]} :
               op_q == 4'd1 ? {24'd0, sh[7:0]} :
               op_q == 4'd2 ? {{16{sh[15]}}, sh[15:0]} :
               op_q == 4'd3 ? {16'd0, sh[15:0]} : readdata;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q <= '0;
         k_q <= '0;
         cnt_q <= '0;
         rdata_q <= '0;
         address_q <= '0;
         writedata_q <= '0;
         be_q <= '0;
         read_q <= 1'b0;
         write_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         k_q <= k_d;
         cnt_q <= cnt_d;
         rdata_q <= rdata_d;
         address_q <= address_d;
         writedata_q <= writedata_d;
         be_q <= be_d;
         read_q <= read_d;
         write_q <= write_d;
         done_q <= done_d;
         err_q <= err_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = is_store ? ISSUE_WR : ISSUE_RD;
            cnt_d = '0;
         end
         ISSUE_RD, ISSUE_WR: begin
            state_d = timeout ? IDLE : waitrequest ? state_q : state_q == ISSUE_RD ? CAPTURE : IDLE;
            cnt_d = waitrequest ? cnt_q + 32'd1 : cnt_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      read_d = state_d == ISSUE_RD;
      write_d = state_d == ISSUE_WR;
      done_d = (state_q == ISSUE_WR && !waitrequest) || state_q == CAPTURE;
      err_d = (state_q == IDLE && req && bad) || (issuing && timeout);
      op_d = start ? op : op_q;
      k_d = start ? k : k_q;
      address_d = start ? {addr[31:2], 2'b00} : address_q;
      be_d = start ? be_sel : be_q;
      writedata_d = start ? wd_sel : writedata_q;
      rdata_d = state_q == CAPTURE ? ld_val : rdata_q;
   end
   assign busy = state_q != IDLE;
   assign done = done_q;
   assign err = err_q;
   assign rdata = rdata_q;
   assign address = address_q;
   assign read = read_q;
   assign write = write_q;
   assign writedata = writedata_q;
   assign byteenable = be_q;
endmodule

// File: tb/tb_mips_cpu_mem_master.sv
// tb_mips_cpu_mem_master: directed checks of the memory master with WAIT_LIMIT=4.
// Builds with or without MIPS_MEM_LWLR_EN; the LWL/LWR expectations follow the macro.
module tb_mips_cpu_mem_master;
   logic clk = 1'b0, reset = 1'b1, req = 1'b0, waitrequest = 1'b0;
   logic [3:0] op = '0;
   logic [31:0] addr = '0, wdata = '0, readdata = '0;
   logic busy, done, err, read, write;
   logic [31:0] rdata, address, writedata;
   logic [3:0] byteenable;
   int n_cmp = 0, n_err = 0;

   mips_cpu_mem_master #(.WAIT_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata), .address(address),
      .read(read), .write(write), .waitrequest(waitrequest), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w, input logic [31:0] rd, input logic wr);
      req = 1'b1; op = o; addr = a; wdata = w; readdata = rd; waitrequest = wr;
   endtask

   initial begin
      step(); step();
      chk("rst_busy", 32'(busy), 0); chk("rst_read", 32'(read), 0); chk("rst_write", 32'(write), 0);
      chk("rst_done", 32'(done), 0); chk("rst_err", 32'(err), 0); chk("rst_rdata", rdata, 0);
      chk("rst_addr", address, 0); chk("rst_be", 32'(byteenable), 0); chk("rst_wd", writedata, 0);
      reset = 1'b0;
      // LW, no wait: read one cycle, done in the third cycle
      issue(4'd4, 32'hBFC0_0010, 0, 32'hDEAD_BEEF, 1'b0);
      step(); req = 1'b0;
      chk("lw_read1", 32'(read), 1); chk("lw_busy", 32'(busy), 1); chk("lw_addr", address, 32'hBFC0_0010);
      chk("lw_be", 32'(byteenable), 32'hF); chk("lw_done1", 32'(done), 0);
      step();
      chk("lw_read2", 32'(read), 0); chk("lw_done2", 32'(done), 0);
      step();
      chk("lw_done3", 32'(done), 1); chk("lw_rdata", rdata, 32'hDEAD_BEEF); chk("lw_err", 32'(err), 0);
      step();
      chk("lw_done4", 32'(done), 0); chk("lw_idle", 32'(busy), 0); chk("lw_hold", rdata, 32'hDEAD_BEEF);
      // LB / LBU at offset 3
      issue(4'd0, 32'hBFC0_0013, 0, 32'h8011_2233, 1'b0);
      step(); req = 1'b0;
      chk("lb_be", 32'(byteenable), 32'b1000); chk("lb_addr", address, 32'hBFC0_0010);
      step(); step();
      chk("lb_done", 32'(done), 1); chk("lb_rdata", rdata, 32'hFFFF_FF80);
      step();
      issue(4'd1, 32'hBFC0_0013, 0, 32'h8011_2233, 1'b0);
      step(); req = 1'b0; step(); step();
      chk("lbu_done", 32'(done), 1); chk("lbu_rdata", rdata, 32'h0000_0080);
      step();
      // SH at offset 2 with three wait cycles
      issue(4'd6, 32'hBFC0_0022, 32'h1234_BEEF, 0, 1'b1);
      step(); req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("sh_write", 32'(write), 1); chk("sh_addr", address, 32'hBFC0_0020);
         chk("sh_be", 32'(byteenable), 32'b1100); chk("sh_wd", writedata, 32'hBEEF_BEEF);
         chk("sh_nodone", 32'(done), 0);
         step();
      end
      chk("sh_write4", 32'(write), 1); chk("sh_wd4", writedata, 32'hBEEF_BEEF);
      waitrequest = 1'b0;
      step();
      chk("sh_done", 32'(done), 1); chk("sh_wrlow", 32'(write), 0); chk("sh_noerr", 32'(err), 0);
      step();
      chk("sh_done_pulse", 32'(done), 0); chk("sh_idle", 32'(busy), 0);
      // misaligned LW and illegal op
      issue(4'd4, 32'hBFC0_0002, 0, 0, 1'b0);
      step(); req = 1'b0;
      chk("mis_err", 32'(err), 1); chk("mis_read", 32'(read), 0); chk("mis_write", 32'(write), 0);
      chk("mis_busy", 32'(busy), 0); chk("mis_done", 32'(done), 0);
      step();
      chk("mis_err_pulse", 32'(err), 0); chk("mis_busy2", 32'(busy), 0);
      issue(4'd12, 32'hBFC0_0000, 0, 0, 1'b0);
      step(); req = 1'b0;
      chk("ill_err", 32'(err), 1); chk("ill_read", 32'(read), 0); chk("ill_busy", 32'(busy), 0);
      step();
      chk("ill_err_pulse", 32'(err), 0);
      // SW timeout after four stalled cycles
      issue(4'd7, 32'hBFC0_0030, 32'h5555_AAAA, 0, 1'b1);
      step(); req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("to_write", 32'(write), 1); chk("to_noerr", 32'(err), 0); chk("to_nodone", 32'(done), 0);
         step();
      end
      chk("to_wrlow", 32'(write), 0); chk("to_err", 32'(err), 1); chk("to_done", 32'(done), 0);
      chk("to_rdata", rdata, 32'h0000_0080);
      step();
      chk("to_err_pulse", 32'(err), 0); chk("to_idle", 32'(busy), 0); chk("to_done2", 32'(done), 0);
      waitrequest = 1'b0;
      // reset in the middle of a read
      issue(4'd4, 32'hBFC0_0040, 0, 32'h1234_5678, 1'b1);
      step(); req = 1'b0;
      chk("rr_read", 32'(read), 1);
      reset = 1'b1;
      step();
      chk("rr_readlow", 32'(read), 0); chk("rr_done", 32'(done), 0); chk("rr_err", 32'(err), 0);
      chk("rr_busy", 32'(busy), 0); chk("rr_rdata", rdata, 0);
      reset = 1'b0; waitrequest = 1'b0;
      step();
      chk("rr_done2", 32'(done), 0); chk("rr_err2", 32'(err), 0);
      // LWL / LWR at offset 1
      issue(4'd8, 32'hBFC0_0001, 32'h1122_3344, 32'hAABB_CCDD, 1'b0);
      step(); req = 1'b0;
`ifdef MIPS_MEM_LWLR_EN
      chk("lwl_read", 32'(read), 1); chk("lwl_be", 32'(byteenable), 32'b0011);
      chk("lwl_addr", address, 32'hBFC0_0000);
      step(); step();
      chk("lwl_done", 32'(done), 1); chk("lwl_rdata", rdata, 32'hCCDD_3344);
      step();
      issue(4'd9, 32'hBFC0_0001, 32'h1122_3344, 32'hAABB_CCDD, 1'b0);
      step(); req = 1'b0;
      chk("lwr_be", 32'(byteenable), 32'b1110);
      step(); step();
      chk("lwr_done", 32'(done), 1); chk("lwr_rdata", rdata, 32'h11AA_BBCC);
`else
      chk("lwl_err", 32'(err), 1); chk("lwl_noread", 32'(read), 0); chk("lwl_busy", 32'(busy), 0);
      step();
      issue(4'd9, 32'hBFC0_0001, 32'h1122_3344, 32'hAABB_CCDD, 1'b0);
      step(); req = 1'b0;
      chk("lwr_err", 32'(err), 1); chk("lwr_noread", 32'(read), 0); chk("lwr_busy", 32'(busy), 0);
`endif
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
